// File: rtl/note_sequencer_pkg.sv
// Shared types, tempo table and sizing helpers for the note sequencer.
package note_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  // Beats per minute selected by tempo_sel.
  localparam int unsigned BPM_TABLE [8] = '{40, 60, 80, 100, 120, 140, 180, 220};

  // Clock cycles per beat; 64-bit intermediate so CLK_HZ*60 cannot overflow.
  function automatic int unsigned period(input longint unsigned clk_hz,
                                         input int unsigned bpm);
    return 32'(clk_hz * 64'd60 / 64'(bpm));
  endfunction

  // Note word width: one STRINGS-wide group per fret position, open included.
  function automatic int unsigned note_w(input int unsigned strings,
                                         input int unsigned frets);
    return strings * (frets + 1);
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control/status bundle between the mode FSM and the note sequencer.
interface note_sequencer_if
  import note_seq_pkg::*;
#(
  parameter int unsigned NOTE_W = 30,
  parameter int unsigned AW     = 6
);
  logic              start;
  logic              stop;
  logic              mode;
  logic              loop;
  logic [2:0]        tempo_sel;
  logic [NOTE_W-1:0] note_out;
  logic              note_valid;
  logic [AW-1:0]     addr;
  logic [AW:0]       length;
  logic              full;
  logic [1:0]        state;

  modport master (
    output start, stop, mode, loop, tempo_sel,
    input  note_out, note_valid, addr, length, full, state
  );

  modport slave (
    input  start, stop, mode, loop, tempo_sel,
    output note_out, note_valid, addr, length, full, state
  );
endinterface

// File: rtl/note_sequencer_beat_timer.sv
// Beat down-counter: one-cycle tick at zero, sampling window outside the guard.
module beat_timer
  import note_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned GUARD  = 10000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       reload,
  input  logic [2:0] tempo_sel,
  output logic       tick,
  output logic       window
);
  // Periods are resolved at elaboration so no divider is built.
  localparam int unsigned PER [8] = '{
    period(CLK_HZ, BPM_TABLE[0]), period(CLK_HZ, BPM_TABLE[1]),
    period(CLK_HZ, BPM_TABLE[2]), period(CLK_HZ, BPM_TABLE[3]),
    period(CLK_HZ, BPM_TABLE[4]), period(CLK_HZ, BPM_TABLE[5]),
    period(CLK_HZ, BPM_TABLE[6]), period(CLK_HZ, BPM_TABLE[7])
  };

  logic [31:0] cnt_q, cnt_d, reload_val;

  assign tick   = (cnt_q == '0);
  assign window = (cnt_q >= GUARD);

  // Next count: reload on tick or start, otherwise count down.
  always_comb begin
    reload_val = PER[tempo_sel] - 32'd1;
    cnt_d      = cnt_q - 32'd1;
    if (reload || tick) cnt_d = reload_val;
  end

  // Counter register; reset loads a full period.
  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= reload_val;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/note_sequencer.sv
// Record/playback engine: samples the contact matrix per beat, stores
// one-hot note words in a DEPTH-entry RAM and plays them back.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned STRINGS = 6,
  parameter int unsigned FRETS   = 4,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned GUARD   = 10000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [STRINGS-1:0] strings,
  input  logic [FRETS-1:0]   frets,
  note_sequencer_if.slave    bus
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned NOTE_W = note_w(STRINGS, FRETS);
  localparam int unsigned FW     = $clog2(FRETS + 1);

  state_t             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [AW:0]        len_q, len_d;
  logic               full_q, full_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic               valid_q, valid_d;
  logic               sel_q, sel_d;
  logic [STRINGS-1:0] str_acc_q, str_acc_d;
  logic [FW-1:0]      fret_acc_q, fret_acc_d;
  logic [FW-1:0]      fret_hi;
  logic [NOTE_W-1:0]  note_enc;
  logic [NOTE_W-1:0]  rd_q;
  logic [NOTE_W-1:0]  mem [DEPTH];
  logic               tick, window, start_ok, last, wr_en, rd_en;

  beat_timer #(.CLK_HZ(CLK_HZ), .GUARD(GUARD)) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .reload    (start_ok),
    .tempo_sel (bus.tempo_sel),
    .tick      (tick),
    .window    (window)
  );

  assign start_ok = bus.start && !bus.stop && (state_q == IDLE) &&
                    (bus.mode || (len_q != '0));
  assign last     = (({1'b0, addr_q} + 1'b1) == len_q);

  // Highest pressed fret index this cycle (0 = open).
  always_comb begin
    fret_hi = '0;
    for (int unsigned k = 0; k < FRETS; k++)
      if (frets[k]) fret_hi = FW'(k + 1);
  end

  // Contact accumulators: gather inside the window, clear on every beat.
  always_comb begin
    str_acc_d  = str_acc_q;
    fret_acc_d = fret_acc_q;
    if (tick) begin
      str_acc_d  = '0;
      fret_acc_d = '0;
    end else if (window) begin
      str_acc_d = str_acc_q | strings;
      if (fret_hi > fret_acc_q) fret_acc_d = fret_hi;
    end
  end

  // One-hot encode: accumulated strings placed in the group of the held fret.
  always_comb begin
    note_enc = '0;
    for (int unsigned f = 0; f <= FRETS; f++)
      for (int unsigned s = 0; s < STRINGS; s++)
        if (FW'(f) == fret_acc_q) note_enc[f*STRINGS + s] = str_acc_q[s];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state; a beat-tick transfer still completes when stop leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = bus.mode ? RECORD : PLAY;
      RECORD:  if (bus.stop || (tick && (len_q + 1'b1 == (AW+1)'(DEPTH))))
                 state_d = IDLE;
      PLAY:    if (bus.stop || (tick && last && !bus.loop)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pointer/length updates, RAM strobes and note register.
  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    full_d  = full_q;
    note_d  = note_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        note_d = '0;
        sel_d  = 1'b0;
        if (start_ok) begin
          addr_d = '0;
          if (bus.mode) begin
            len_d  = '0;
            full_d = 1'b0;
          end
        end
      end
      RECORD: if (tick) begin
        wr_en   = 1'b1;
        addr_d  = addr_q + 1'b1;
        len_d   = len_q + 1'b1;
        note_d  = note_enc;
        sel_d   = 1'b0;
        valid_d = 1'b1;
        if (len_q + 1'b1 == (AW+1)'(DEPTH)) full_d = 1'b1;
      end
      PLAY: if (tick) begin
        rd_en   = 1'b1;
        sel_d   = 1'b1;
        valid_d = 1'b1;
        addr_d  = (last && bus.loop) ? '0 : addr_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q     <= '0;
      len_q      <= '0;
      full_q     <= 1'b0;
      note_q     <= '0;
      valid_q    <= 1'b0;
      sel_q      <= 1'b0;
      str_acc_q  <= '0;
      fret_acc_q <= '0;
    end else begin
      addr_q     <= addr_d;
      len_q      <= len_d;
      full_q     <= full_d;
      note_q     <= note_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      str_acc_q  <= str_acc_d;
      fret_acc_q <= fret_acc_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && resetn) mem[addr_q] <= note_enc;
  end

  // RAM synchronous read port.
  always_ff @(posedge clk) begin
    if (rd_en) rd_q <= mem[addr_q];
  end

  // Played words come straight from the RAM read register; sel_q picks the source.
  assign bus.note_out   = sel_q ? rd_q : note_q;
  assign bus.note_valid = valid_q;
  assign bus.addr       = addr_q;
  assign bus.length     = len_q;
  assign bus.full       = full_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer at CLK_HZ=600, 60 BPM (P=600), DEPTH=4.
module tb_note_sequencer;
  localparam int unsigned STRINGS = 6;
  localparam int unsigned FRETS   = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CLK_HZ  = 600;
  localparam int unsigned GUARD   = 2;
  localparam int unsigned P       = 600;
  localparam int unsigned NW      = 30;
  localparam int unsigned AW      = 2;

  logic         clk = 1'b0;
  logic         resetn;
  logic [5:0]   strings;
  logic [3:0]   frets;

  note_sequencer_if #(.NOTE_W(NW), .AW(AW)) bus ();

  note_sequencer #(
    .STRINGS (STRINGS),
    .FRETS   (FRETS),
    .DEPTH   (DEPTH),
    .CLK_HZ  (CLK_HZ),
    .GUARD   (GUARD)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .strings (strings),
    .frets   (frets),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  s;
    logic [3:0]  f;
    bit          late;
    logic [29:0] word;
  } beat_vec_t;

  beat_vec_t   rec_tab [4];
  int unsigned ord     [3];
  logic [29:0] exp_mem [3];
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One beat of P cycles; contacts driven inside the window or only in the guard.
  task automatic run_beat(input logic [5:0] s, input logic [3:0] f, input bit late);
    for (int i = 0; i < int'(P); i++) begin
      @(negedge clk);
      if ((late && i >= int'(P - GUARD)) || (!late && i < int'(P - GUARD))) begin
        strings = s;
        frets   = f;
      end else begin
        strings = '0;
        frets   = '0;
      end
      @(posedge clk);
      if (i == 0) begin
        #1;
        check("valid_one_cycle", 32'(bus.note_valid), 0);
      end
    end
    #1;
    strings = '0;
    frets   = '0;
  endtask

  task automatic do_start(input logic m, input logic l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.loop  = l;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    bus.stop = 1'b1;
    @(posedge clk);
    #1 bus.stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rec_tab[0] = '{6'b000100, 4'b0010, 1'b0, 30'h0000_4000};
    rec_tab[1] = '{6'b100001, 4'b0101, 1'b0, 30'h0084_0000};
    rec_tab[2] = '{6'b010010, 4'b0000, 1'b0, 30'h0000_0012};
    rec_tab[3] = '{6'b111111, 4'b1000, 1'b1, 30'h0000_0000};
    ord[0] = 2; ord[1] = 0; ord[2] = 1;
    for (int j = 0; j < 3; j++) exp_mem[j] = rec_tab[ord[j]].word;

    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0; bus.loop = 1'b0;
    bus.tempo_sel = 3'd1;
    strings = '0; frets = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.state), 0);
    check("rst_addr", 32'(bus.addr), 0);
    check("rst_length", 32'(bus.length), 0);
    check("rst_full", 32'(bus.full), 0);
    check("rst_note", 32'(bus.note_out), 0);
    check("rst_valid", 32'(bus.note_valid), 0);

    do_start(1'b0, 1'b0);
    check("play_empty_ignored", 32'(bus.state), 0);
    repeat (5) @(posedge clk);
    #1 check("play_empty_still_idle", 32'(bus.state), 0);

    // Record until full.
    do_start(1'b1, 1'b0);
    check("rec_enter", 32'(bus.state), 1);
    for (int k = 0; k < 4; k++) begin
      run_beat(rec_tab[k].s, rec_tab[k].f, rec_tab[k].late);
      check("rec_valid", 32'(bus.note_valid), 1);
      check("rec_word", 32'(bus.note_out), 32'(rec_tab[k].word));
      check("rec_length", 32'(bus.length), k + 1);
      check("rec_addr", 32'(bus.addr), (k + 1) % int'(DEPTH));
      check("rec_state", 32'(bus.state), (k < 3) ? 1 : 0);
      check("rec_full", 32'(bus.full), (k == 3) ? 1 : 0);
    end

    // Re-record three entries in a new order, then stop.
    do_start(1'b1, 1'b0);
    check("rerec_full_clear", 32'(bus.full), 0);
    check("rerec_length", 32'(bus.length), 0);
    for (int j = 0; j < 3; j++) begin
      run_beat(rec_tab[ord[j]].s, rec_tab[ord[j]].f, 1'b0);
      check("rerec_word", 32'(bus.note_out), 32'(exp_mem[j]));
      check("rerec_length", 32'(bus.length), j + 1);
    end
    do_stop();
    check("rerec_stop_state", 32'(bus.state), 0);
    check("rerec_stop_length", 32'(bus.length), 3);

    // Play once through.
    do_start(1'b0, 1'b0);
    check("play_enter", 32'(bus.state), 2);
    check("play_addr0", 32'(bus.addr), 0);
    for (int j = 0; j < 3; j++) begin
      run_beat('0, '0, 1'b0);
      check("play_valid", 32'(bus.note_valid), 1);
      check("play_word", 32'(bus.note_out), 32'(exp_mem[j]));
      check("play_state", 32'(bus.state), (j < 2) ? 2 : 0);
      if (j < 2) check("play_addr", 32'(bus.addr), j + 1);
    end
    @(posedge clk);
    #1;
    check("play_end_note", 32'(bus.note_out), 0);
    check("play_end_valid", 32'(bus.note_valid), 0);

    // start and stop together from IDLE: nothing happens.
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1; bus.mode = 1'b0;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.stop = 1'b0; end
    check("start_stop_play", 32'(bus.state), 0);
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1; bus.mode = 1'b1;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.stop = 1'b0; end
    check("start_stop_rec", 32'(bus.state), 0);
    check("start_stop_len", 32'(bus.length), 3);

    // Looping playback wraps to entry 0.
    do_start(1'b0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      run_beat('0, '0, 1'b0);
      check("loop_word", 32'(bus.note_out), 32'(exp_mem[j % 3]));
      check("loop_addr", 32'(bus.addr), (j + 1) % 3);
      check("loop_state", 32'(bus.state), 2);
    end
    do_stop();
    check("loop_stop_state", 32'(bus.state), 0);
    @(posedge clk);
    #1 check("loop_stop_note", 32'(bus.note_out), 0);

    // Reset in the middle of playback.
    do_start(1'b0, 1'b1);
    run_beat('0, '0, 1'b0);
    check("mid_word", 32'(bus.note_out), 32'(exp_mem[0]));
    repeat (100) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    check("mid_rst_state", 32'(bus.state), 0);
    check("mid_rst_length", 32'(bus.length), 0);
    check("mid_rst_note", 32'(bus.note_out), 0);
    check("mid_rst_addr", 32'(bus.addr), 0);
    check("mid_rst_valid", 32'(bus.note_valid), 0);
    do_start(1'b0, 1'b0);
    check("post_rst_play_ignored", 32'(bus.state), 0);
    repeat (10) @(posedge clk);
    #1 check("post_rst_idle", 32'(bus.state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
